// File: rtl/enum_stepper.sv
// enum_stepper: steps or searches through a fixed table of enumerated values under handshake commands
module enum_stepper #(
    parameter int WIDTH = 60,
    parameter int COUNT = 3,
    parameter logic [COUNT*WIDTH-1:0] VALUES = {60'h0FF, 60'h1234_4567_abcd, 60'h1},
    localparam int IDXW = ($clog2(COUNT) > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] value,
    output logic [IDXW-1:0]  index,
    output logic             known,
    output logic             rsp_valid,
    output logic             rsp_ok
);
    typedef enum logic [1:0] {IDLE, SEARCH, STEP, RESP} state_t;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_NEXT  = 2'b01;
    localparam logic [1:0] OP_PREV  = 2'b10;
    localparam logic [1:0] OP_FORCE = 2'b11;
    localparam logic [IDXW-1:0] LAST = IDXW'(COUNT - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  value_q, arg_q;
    logic [IDXW-1:0]   idx_q, k_q, step_d;
    logic              known_q, ok_q;
    logic [1:0]        op_q;
    logic [15:0]       cnt_q, n_d;

    function automatic logic [WIDTH-1:0] entry(input logic [IDXW-1:0] i);
        return VALUES[i*WIDTH +: WIDTH];
    endfunction

    assign cmd_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = (state_q == RESP);
    assign rsp_ok    = ok_q;
    assign value     = value_q;
    assign index     = idx_q;
    assign known     = known_q;

    // Step count from the low 16 argument bits and the neighbouring index with wrap-around
    always_comb begin
        n_d    = 16'(cmd_arg);
        step_d = (op_q == OP_NEXT) ? ((idx_q == LAST) ? '0 : idx_q + 1'b1)
                                   : ((idx_q == '0) ? LAST : idx_q - 1'b1);
    end

    // Command FSM: accept, linear table search or n-cycle stepping, then a one-cycle response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            value_q <= entry('0);
            idx_q   <= '0;
            known_q <= 1'b1;
            ok_q    <= 1'b0;
            op_q    <= OP_LOAD;
            arg_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_q  <= cmd_op;
                    arg_q <= cmd_arg;
                    k_q   <= '0;
                    cnt_q <= n_d;
                    if (cmd_op == OP_LOAD || cmd_op == OP_FORCE) begin
                        state_q <= SEARCH;
                    end else if (n_d == '0 || !known_q) begin
                        ok_q    <= known_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= STEP;
                    end
                end
                SEARCH: if (arg_q == entry(k_q)) begin
                    value_q <= entry(k_q);
                    idx_q   <= k_q;
                    known_q <= 1'b1;
                    ok_q    <= 1'b1;
                    state_q <= RESP;
                end else if (k_q == LAST) begin
                    if (op_q == OP_FORCE) begin
                        value_q <= arg_q;
                        idx_q   <= '0;
                        known_q <= 1'b0;
                    end
                    ok_q    <= 1'b0;
                    state_q <= RESP;
                end else begin
                    k_q <= k_q + 1'b1;
                end
                STEP: begin
                    idx_q   <= step_d;
                    value_q <= entry(step_d);
                    cnt_q   <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        ok_q    <= 1'b1;
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // PREV is the only op that reaches STEP besides NEXT
    logic unused_ok;
    assign unused_ok = (OP_PREV == 2'b10);
endmodule

// File: doc/enum_stepper.md
ENUM_STEPPER -- requirements
Module: enum_stepper

Interface
REQ-001 SHALL have parameter WIDTH, default 60, the bit width of one enumerated value.
REQ-002 SHALL have parameter COUNT, default 3, the number of legal values; COUNT >= 2.
REQ-003 SHALL have parameter VALUES, default {60'h0FF, 60'h1234_4567_abcd, 60'h1}: COUNT*WIDTH bits, entry i at bits [i*WIDTH +: WIDTH]; entries distinct; entry order defines next/prev order.
REQ-004 SHALL define localparam IDXW = max(1, $clog2(COUNT)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-008 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-009 SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 NEXT, 10 PREV, 11 FORCE.
REQ-010 SHALL have port cmd_arg, input, WIDTH bits: the value for LOAD/FORCE; for NEXT/PREV, step count n = cmd_arg[15:0], zero-extended if WIDTH < 16.
REQ-011 SHALL have port value, output, WIDTH bits: current value.
REQ-012 SHALL have port index, output, IDXW bits: table index of value (0 when unknown).
REQ-013 SHALL have port known, output, 1 bit: value matches a table entry.
REQ-014 SHALL have ports rsp_valid (1-bit pulse) and rsp_ok (1 bit), both outputs: command completion and success.

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH, STEP, RESP; cmd_ready = (state==IDLE) && rst_n.
REQ-016 SHALL accept a command on a clock edge with cmd_valid && cmd_ready; cmd_valid is ignored in all other states; cmd_op/cmd_arg are registered at accept.
REQ-017 LOAD/FORCE SHALL enter SEARCH and compare one entry per cycle, k = 0, 1, ...; on a match at k, or after k = COUNT-1, go to RESP.
REQ-018 Search hit at index i SHALL set value = entry i, index = i, known = 1, rsp_ok = 1; rsp_valid high in cycle i+2, where the accept cycle is cycle 0.
REQ-019 LOAD miss SHALL leave value/index/known unchanged, rsp_ok = 0, rsp_valid in cycle COUNT+1.
REQ-020 FORCE miss SHALL set value = cmd_arg, index = 0, known = 0, rsp_ok = 0, rsp_valid in cycle COUNT+1.
REQ-021 NEXT/PREV with known = 1 SHALL enter STEP for n cycles, advancing index by one per cycle (value follows the table), then RESP; rsp_valid in cycle n+1; rsp_ok = 1.
REQ-022 NEXT SHALL wrap from COUNT-1 to 0; PREV SHALL wrap from 0 to COUNT-1.
REQ-023 n = 0 SHALL go directly to RESP, state unchanged, rsp_ok = 1, rsp_valid in cycle 1.
REQ-024 NEXT/PREV with known = 0 SHALL go directly to RESP, state unchanged, rsp_ok = 0, rsp_valid in cycle 1.
REQ-025 RESP SHALL last exactly one cycle, then IDLE; rsp_valid SHALL be high only in RESP; rsp_ok SHALL hold its value until the next RESP.
REQ-026 A command SHALL be acceptable in the cycle after RESP (back-to-back throughput).

Reset
REQ-027 With rst_n low at a clock edge: value = entry 0, index = 0, known = 1, state = IDLE, rsp_valid = 0, rsp_ok = 0.
REQ-028 Reset in any state SHALL abort the command with no rsp_valid; the partially stepped value is discarded.
REQ-029 cmd_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Verification (defaults: entries 0/1/2 = 'h1 / 'h1234_4567_abcd / 'h0FF)
REQ-030 Release reset -> value = 'h1, index = 0, known = 1, cmd_ready = 1.
REQ-031 NEXT n=1 from index 0 -> rsp_valid in cycle 2, value = 'h1234_4567_abcd; then NEXT n=2 -> index 2 then 0, value = 'h1, rsp_valid in cycle 3.
REQ-032 PREV n=1 from index 0 -> index = 2, value = 'h0FF, rsp_ok = 1; NEXT n=0 -> rsp_valid in cycle 1, no change.
REQ-033 LOAD 'h1234 -> rsp_ok = 0 in cycle 4, value unchanged; LOAD 'h1234_4567_abcd -> rsp_ok = 1 in cycle 3, index = 1.
REQ-034 FORCE 'h11 -> known = 0, value = 'h11, rsp_ok = 0; then NEXT n=1 -> rsp_ok = 0, value stays 'h11; then LOAD 'h1 -> known = 1, index = 0.
REQ-035 rst_n low in cycle 3 of NEXT n=5 -> no rsp_valid, value = 'h1; a cmd_valid pulse during STEP is ignored.
